cache_ctrl_assoc: RTL and testbench
===================================

# cache_ctrl_assoc

Control FSM for a parametrised WAYS-way set-associative, write-back, write-allocate cache with multi-word blocks. It sits between the CPU port and the lower-level memory port, and drives the tag/valid/dirty arrays and the per-way data arrays. Hits are serviced in the lookup cycle. Misses select a victim way, write the victim back word by word if it is dirty, then refill the block with a WORDS-beat burst and replay the lookup. The tag compare and the data muxes live in the datapath; this block only produces selects and enables.

## Interface
Parameters:
- WAYS, 2: associativity. Power of 2, range 1..8. WAY_W = max(1, log2(WAYS)).
- WORDS, 4: words per block. Power of 2, range 2..16. WSEL_W = log2(WORDS).
- BYTES, 4: bytes per word.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_cpu  in  1  CPU request valid; held until rdy_cpu
- wr_cpu  in  1  1 = write, 0 = read
- be_cpu  in  BYTES  CPU write byte enables
- word_sel  in  WSEL_W  word offset of the CPU address
- rdy_cpu  out  1  CPU access completes this cycle
- hit_way  in  WAYS  per-way tag match, already qualified with valid
- valid_way  in  WAYS  valid bits of the indexed set
- dirty_way  in  WAYS  dirty bits of the indexed set
- req_low  out  1  memory transfer active
- wr_low  out  1  1 = writeback beat, 0 = refill beat
- beat_low  out  WSEL_W  current beat / word index
- rdy_low  in  1  memory accepted or returned the current beat
- way_we  out  WAYS  one-hot data-array write enable
- word_en  out  WORDS  one-hot word enable
- byte_en  out  BYTES  byte enables for array writes
- data_sel  out  1  array write data: 0 = CPU, 1 = memory
- rd_way  out  WAY_W  way select for the read and writeback mux
- tag_we  out  1  write tag, valid and dirty of way rd_way
- valid_new  out  1  valid bit to write
- dirty_new  out  1  dirty bit to write
- asel  out  1  memory address: 0 = CPU tag, 1 = victim tag

## Operation
States: INIT, LOOKUP, WB, REFILL.
- INIT: entered on rst. Lasts exactly 1 cycle after rst deasserts, then goes to LOOKUP. All outputs are 0 in INIT and during rst.
- LOOKUP, hit (req_cpu and |hit_way):
  - rdy_cpu=1.
  - rd_way = index of the lowest set bit of hit_way.
  - On write: way_we = that way, one-hot; word_en = onehot(word_sel); byte_en = be_cpu; data_sel=0; tag_we=1; valid_new=1; dirty_new=1.
  - On read: no enables asserted.
  - Stay in LOOKUP.
- LOOKUP, miss (req_cpu and ~|hit_way):
  - rdy_cpu=0.
  - Victim = lowest-index way with valid_way=0. If every way is valid, victim = rr_ptr, and rr_ptr increments (mod WAYS) at this edge.
  - Latch victim into a register.
  - Next state: WB if valid_way[victim] and dirty_way[victim]; otherwise REFILL.
- LOOKUP, no request: all outputs 0; stay in LOOKUP.
- WB:
  - req_low=1, wr_low=1, asel=1, rd_way=victim, beat_low=beat.
  - beat increments on rdy_low.
  - rdy_low on beat WORDS-1 clears beat and moves to REFILL.
- REFILL:
  - req_low=1, wr_low=0, beat_low=beat, rd_way=victim.
  - On rdy_low: way_we = onehot(victim); word_en = onehot(beat); byte_en = all 1; data_sel=1.
  - On the last beat with rdy_low, additionally: tag_we=1, valid_new=1, dirty_new=0. Clear beat and go to LOOKUP.
- Replay: the request is looked up again after the refill and now hits. A write therefore merges its data and sets dirty in the replay cycle.
- rr_ptr (WAY_W bits) and beat (WSEL_W bits) reset to 0. When WAYS=1 the victim is always way 0.
- Boundaries:
  - req_cpu dropping during WB or REFILL has no effect; the burst completes, then the FSM returns to LOOKUP.
  - Multiple hit_way bits set: lowest index wins.
  - rst mid-burst: abort immediately to INIT, beat=0, rr_ptr=0, req_low=0 within the same cycle.

## Timing
- All outputs are combinational from state, registers and inputs. No output depends on a registered copy of the CPU inputs.
- Hit latency: rdy_cpu is asserted in the same cycle req_cpu is presented in LOOKUP.
- Each beat lasts ≥1 cycle. req_low stays high continuously across all beats, including wait cycles with rdy_low=0.
- Clean miss with rdy_low tied to 1, WORDS=4: LOOKUP in cycle 1, REFILL in cycles 2-5, rdy_cpu in cycle 6.
- Dirty miss with rdy_low tied to 1, WORDS=4: WB in cycles 2-5, REFILL in cycles 6-9, rdy_cpu in cycle 10.
- Each rdy_low wait cycle adds exactly 1 cycle.
- rr_ptr advances only on a miss in which all ways are valid.

## Test plan
- Reset, then read with hit_way=2'b10, word_sel=2: rdy_cpu=1 in that cycle, rd_way=1, way_we=0.
- Write hit with hit_way=2'b01, word_sel=3, be_cpu=4'b0110: way_we=01, word_en=1000, byte_en=0110, data_sel=0, dirty_new=1, rdy_cpu=1.
- Clean miss with valid_way=01 and rdy_low=1: victim=1; refill beats 0..3 with way_we=10; tag_we and valid_new=1 on beat 3; rdy_cpu in cycle 6.
- Dirty miss with all ways valid, dirty_way=11, rr_ptr=0, rdy_low high every other cycle:
  - WB beats 0..3 to way 0 with asel=1, then the refill.
  - rr_ptr=1 afterwards; rdy_cpu in cycle 18.
- Back-to-back full-set misses: victims cycle 0,1,0,1.
- rst pulse during REFILL beat 2: req_low=0 immediately, 1 INIT cycle, a fresh miss restarts at beat 0.

Source files
------------

// File: rtl/cache_ctrl_assoc_if.sv
// Signal bundle between the associative cache controller and its CPU port, memory port and arrays.
// master is the surrounding datapath/CPU/memory side, slave is the controller itself.
interface cache_ctrl_assoc_if #(
   parameter int WAYS  = 2,
   parameter int WORDS = 4,
   parameter int BYTES = 4
);
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int WSEL_W = $clog2(WORDS);

   logic              req_cpu;
   logic              wr_cpu;
   logic [BYTES-1:0]  be_cpu;
   logic [WSEL_W-1:0] word_sel;
   logic              rdy_cpu;
   logic [WAYS-1:0]   hit_way;
   logic [WAYS-1:0]   valid_way;
   logic [WAYS-1:0]   dirty_way;
   logic              req_low;
   logic              wr_low;
   logic [WSEL_W-1:0] beat_low;
   logic              rdy_low;
   logic [WAYS-1:0]   way_we;
   logic [WORDS-1:0]  word_en;
   logic [BYTES-1:0]  byte_en;
   logic              data_sel;
   logic [WAY_W-1:0]  rd_way;
   logic              tag_we;
   logic              valid_new;
   logic              dirty_new;
   logic              asel;

   modport master (
      output req_cpu, wr_cpu, be_cpu, word_sel, hit_way, valid_way, dirty_way, rdy_low,
      input  rdy_cpu, req_low, wr_low, beat_low, way_we, word_en, byte_en, data_sel,
             rd_way, tag_we, valid_new, dirty_new, asel
   );

   modport slave (
      input  req_cpu, wr_cpu, be_cpu, word_sel, hit_way, valid_way, dirty_way, rdy_low,
      output rdy_cpu, req_low, wr_low, beat_low, way_we, word_en, byte_en, data_sel,
             rd_way, tag_we, valid_new, dirty_new, asel
   );
endinterface

// File: rtl/cache_ctrl_assoc.sv
// Control FSM for a WAYS-way set-associative write-back, write-allocate cache with
// word-by-word victim writeback and a WORDS-beat refill followed by a replayed lookup.
module cache_ctrl_assoc #(
   parameter int WAYS  = 2,
   parameter int WORDS = 4,
   parameter int BYTES = 4
) (
   input logic               clk,
   input logic               rst,
   cache_ctrl_assoc_if.slave bus
);
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int WSEL_W = $clog2(WORDS);
   localparam logic [WSEL_W-1:0] LAST_BEAT = WSEL_W'(WORDS - 1);

   typedef enum logic [1:0] {S_INIT, S_LOOKUP, S_WB, S_REFILL} state_t;

   state_t            state_reg, state_next;
   logic [WAY_W-1:0]  victim_reg, victim_next;
   logic [WAY_W-1:0]  rr_ptr_reg, rr_ptr_next;
   logic [WSEL_W-1:0] beat_reg, beat_next;

   logic [WAY_W-1:0]  hit_idx;
   logic [WAY_W-1:0]  free_idx;
   logic [WAY_W-1:0]  victim_sel;
   logic              any_hit;
   logic              any_free;
   logic              last_beat;

   // Descending scan so the lowest matching index is the one that sticks.
   always_comb begin
      hit_idx  = '0;
      free_idx = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (bus.hit_way[i])
            hit_idx = WAY_W'(i);
         if (!bus.valid_way[i])
            free_idx = WAY_W'(i);
      end
   end

   assign any_hit    = |bus.hit_way;
   assign any_free   = ~&bus.valid_way;
   assign victim_sel = any_free ? free_idx : rr_ptr_reg;
   assign last_beat  = (beat_reg == LAST_BEAT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= S_INIT;
         victim_reg <= '0;
         rr_ptr_reg <= '0;
         beat_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         victim_reg <= victim_next;
         rr_ptr_reg <= rr_ptr_next;
         beat_reg   <= beat_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      victim_next = victim_reg;
      rr_ptr_next = rr_ptr_reg;
      beat_next   = beat_reg;
      case (state_reg)
         S_INIT: state_next = S_LOOKUP;
         S_LOOKUP: begin
            if (bus.req_cpu && !any_hit) begin
               victim_next = victim_sel;
               // Round-robin only advances when no free way absorbed the miss.
               if (!any_free && (WAYS > 1))
                  rr_ptr_next = rr_ptr_reg + 1'b1;
               state_next = (bus.valid_way[victim_sel] && bus.dirty_way[victim_sel]) ? S_WB : S_REFILL;
            end
         end
         S_WB: begin
            if (bus.rdy_low) begin
               beat_next = beat_reg + 1'b1;
               if (last_beat) begin
                  beat_next  = '0;
                  state_next = S_REFILL;
               end
            end
         end
         S_REFILL: begin
            if (bus.rdy_low) begin
               beat_next = beat_reg + 1'b1;
               if (last_beat) begin
                  beat_next  = '0;
                  state_next = S_LOOKUP;
               end
            end
         end
         default: state_next = S_INIT;
      endcase
   end

   always_comb begin
      bus.rdy_cpu   = 1'b0;
      bus.req_low   = 1'b0;
      bus.wr_low    = 1'b0;
      bus.beat_low  = '0;
      bus.way_we    = '0;
      bus.word_en   = '0;
      bus.byte_en   = '0;
      bus.data_sel  = 1'b0;
      bus.rd_way    = '0;
      bus.tag_we    = 1'b0;
      bus.valid_new = 1'b0;
      bus.dirty_new = 1'b0;
      bus.asel      = 1'b0;
      case (state_reg)
         S_LOOKUP: begin
            if (bus.req_cpu && any_hit) begin
               bus.rdy_cpu = 1'b1;
               bus.rd_way  = hit_idx;
               if (bus.wr_cpu) begin
                  bus.way_we    = WAYS'(1) << hit_idx;
                  bus.word_en   = WORDS'(1) << bus.word_sel;
                  bus.byte_en   = bus.be_cpu;
                  bus.tag_we    = 1'b1;
                  bus.valid_new = 1'b1;
                  bus.dirty_new = 1'b1;
               end
            end
         end
         S_WB: begin
            bus.req_low  = 1'b1;
            bus.wr_low   = 1'b1;
            bus.asel     = 1'b1;
            bus.rd_way   = victim_reg;
            bus.beat_low = beat_reg;
         end
         S_REFILL: begin
            bus.req_low  = 1'b1;
            bus.rd_way   = victim_reg;
            bus.beat_low = beat_reg;
            if (bus.rdy_low) begin
               bus.way_we   = WAYS'(1) << victim_reg;
               bus.word_en  = WORDS'(1) << beat_reg;
               bus.byte_en  = '1;
               bus.data_sel = 1'b1;
               if (last_beat) begin
                  bus.tag_we    = 1'b1;
                  bus.valid_new = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Self-checking bench: directed scenarios plus random traffic against a one-set cache model
// that expands every access into its expected per-cycle controller outputs.
module tb_cache_ctrl_assoc;
   localparam int WAYS   = 2;
   localparam int WORDS  = 4;
   localparam int BYTES  = 4;
   localparam int WAY_W  = 1;
   localparam int WSEL_W = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cache_ctrl_assoc_if #(.WAYS(WAYS), .WORDS(WORDS), .BYTES(BYTES)) bus ();

   cache_ctrl_assoc #(.WAYS(WAYS), .WORDS(WORDS), .BYTES(BYTES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic              e_rdy_cpu, e_req_low, e_wr_low, e_data_sel;
   logic              e_tag_we, e_valid_new, e_dirty_new, e_asel;
   logic [WSEL_W-1:0] e_beat_low;
   logic [WAYS-1:0]   e_way_we;
   logic [WORDS-1:0]  e_word_en;
   logic [BYTES-1:0]  e_byte_en;
   logic [WAY_W-1:0]  e_rd_way;

   // Contents of the single indexed set as the cache would hold it.
   bit m_valid [WAYS];
   bit m_dirty [WAYS];
   int m_tag   [WAYS];
   int m_rr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic clr_exp();
      e_rdy_cpu = 0; e_req_low = 0; e_wr_low = 0; e_data_sel = 0;
      e_tag_we = 0; e_valid_new = 0; e_dirty_new = 0; e_asel = 0;
      e_beat_low = '0; e_way_we = '0; e_word_en = '0; e_byte_en = '0; e_rd_way = '0;
   endtask

   task automatic compare_all();
      chk("rdy_cpu",   32'(bus.rdy_cpu),   32'(e_rdy_cpu));
      chk("req_low",   32'(bus.req_low),   32'(e_req_low));
      chk("wr_low",    32'(bus.wr_low),    32'(e_wr_low));
      chk("beat_low",  32'(bus.beat_low),  32'(e_beat_low));
      chk("way_we",    32'(bus.way_we),    32'(e_way_we));
      chk("word_en",   32'(bus.word_en),   32'(e_word_en));
      chk("byte_en",   32'(bus.byte_en),   32'(e_byte_en));
      chk("data_sel",  32'(bus.data_sel),  32'(e_data_sel));
      chk("rd_way",    32'(bus.rd_way),    32'(e_rd_way));
      chk("tag_we",    32'(bus.tag_we),    32'(e_tag_we));
      chk("valid_new", 32'(bus.valid_new), 32'(e_valid_new));
      chk("dirty_new", 32'(bus.dirty_new), 32'(e_dirty_new));
      chk("asel",      32'(bus.asel),      32'(e_asel));
   endtask

   // One clock cycle: outputs checked on the falling edge, inputs changed 1 after the rising edge.
   task automatic tick();
      cyc++;
      @(negedge clk);
      compare_all();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < WAYS; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
         m_tag[i]   = -1;
      end
      m_rr = 0;
   endtask

   task automatic drive_set(input int tag);
      for (int i = 0; i < WAYS; i++) begin
         bus.hit_way[i]   = m_valid[i] && (m_tag[i] == tag);
         bus.valid_way[i] = m_valid[i];
         bus.dirty_way[i] = m_dirty[i];
      end
   endtask

   task automatic set_burst_exp(input bit wb, input int v, input int b, input bit acc);
      clr_exp();
      e_req_low  = 1;
      e_wr_low   = wb;
      e_beat_low = WSEL_W'(b);
      e_rd_way   = WAY_W'(v);
      if (wb) begin
         e_asel = 1;
      end else if (acc) begin
         e_way_we   = WAYS'(1) << v;
         e_word_en  = WORDS'(1) << b;
         e_byte_en  = '1;
         e_data_sel = 1;
         if (b == WORDS - 1) begin
            e_tag_we    = 1;
            e_valid_new = 1;
         end
      end
   endtask

   // wmode: 0 = memory always ready, 1 = one wait per beat, 2 = random waits with CPU request wobbling.
   task automatic burst_beat(input bit wb, input int v, input int b, input int wmode);
      int waits;
      waits = (wmode == 0) ? 0 : (wmode == 1) ? 1 : int'($urandom_range(0, 2));
      for (int k = 0; k < waits; k++) begin
         bus.rdy_low = 0;
         if (wmode == 2)
            bus.req_cpu = 1'($urandom_range(0, 1));
         set_burst_exp(wb, v, b, 0);
         tick();
      end
      bus.rdy_low = 1;
      set_burst_exp(wb, v, b, 1);
      tick();
   endtask

   task automatic access(input bit wr, input int tag, input int ws, input logic [BYTES-1:0] be,
                         input int wmode, output int lat);
      int h;
      int v;
      cyc = 0;
      bus.req_cpu  = 1;
      bus.wr_cpu   = wr;
      bus.be_cpu   = be;
      bus.word_sel = WSEL_W'(ws);
      bus.rdy_low  = 1'($urandom_range(0, 1));
      drive_set(tag);
      h = -1;
      for (int i = WAYS - 1; i >= 0; i--)
         if (m_valid[i] && m_tag[i] == tag)
            h = i;
      if (h < 0) begin
         clr_exp();
         tick();
         v = -1;
         for (int i = 0; i < WAYS; i++)
            if (!m_valid[i] && v < 0)
               v = i;
         if (v < 0) begin
            v    = m_rr;
            m_rr = (m_rr + 1) % WAYS;
         end
         if (m_valid[v] && m_dirty[v])
            for (int b = 0; b < WORDS; b++)
               burst_beat(1, v, b, wmode);
         for (int b = 0; b < WORDS; b++)
            burst_beat(0, v, b, wmode);
         m_tag[v]   = tag;
         m_valid[v] = 1;
         m_dirty[v] = 0;
         bus.req_cpu = 1;
         drive_set(tag);
         h = v;
      end
      clr_exp();
      e_rdy_cpu = 1;
      e_rd_way  = WAY_W'(h);
      if (wr) begin
         e_way_we    = WAYS'(1) << h;
         e_word_en   = WORDS'(1) << ws;
         e_byte_en   = be;
         e_tag_we    = 1;
         e_valid_new = 1;
         e_dirty_new = 1;
         m_dirty[h]  = 1;
      end
      tick();
      lat = cyc;
      bus.req_cpu = 0;
   endtask

   task automatic idle();
      bus.req_cpu   = 0;
      bus.wr_cpu    = 1'($urandom_range(0, 1));
      bus.hit_way   = WAYS'($urandom);
      bus.valid_way = WAYS'($urandom);
      bus.dirty_way = WAYS'($urandom);
      bus.rdy_low   = 1'($urandom_range(0, 1));
      clr_exp();
      tick();
   endtask

   initial begin
      int lat;
      bus.req_cpu = 0; bus.wr_cpu = 0; bus.be_cpu = '0; bus.word_sel = '0;
      bus.hit_way = '0; bus.valid_way = '0; bus.dirty_way = '0; bus.rdy_low = 0;
      model_reset();

      // Reset and INIT keep every output low even with a hitting request presented.
      bus.req_cpu = 1; bus.hit_way = 2'b10; bus.valid_way = 2'b11; bus.rdy_low = 1;
      clr_exp(); tick(); tick();
      rst = 0;
      clr_exp(); tick();

      bus.wr_cpu = 0; bus.word_sel = 2'd2;
      clr_exp(); e_rdy_cpu = 1; e_rd_way = 1'b1; tick();

      bus.wr_cpu = 1; bus.hit_way = 2'b01; bus.word_sel = 2'd3; bus.be_cpu = 4'b0110;
      clr_exp(); e_rdy_cpu = 1; e_rd_way = 1'b0; e_way_we = 2'b01; e_word_en = 4'b1000;
      e_byte_en = 4'b0110; e_tag_we = 1; e_valid_new = 1; e_dirty_new = 1; tick();

      bus.wr_cpu = 0; bus.hit_way = 2'b11;
      clr_exp(); e_rdy_cpu = 1; e_rd_way = 1'b0; tick();

      idle();

      m_valid[0] = 1; m_tag[0] = 5;
      access(0, 6, 1, 4'hF, 0, lat);
      chk("clean_miss_latency", 32'(lat), 32'd6);

      m_dirty[0] = 1; m_dirty[1] = 1;
      access(0, 7, 0, 4'hF, 1, lat);
      chk("dirty_miss_latency", 32'(lat), 32'd18);

      // Reset pulse in the middle of a refill burst.
      bus.req_cpu = 1; bus.wr_cpu = 0; bus.hit_way = '0; bus.valid_way = '0;
      bus.dirty_way = '0; bus.rdy_low = 1;
      clr_exp(); tick();
      set_burst_exp(0, 0, 0, 1); tick();
      set_burst_exp(0, 0, 1, 1); tick();
      set_burst_exp(0, 0, 2, 1);
      @(negedge clk);
      compare_all();
      #1 rst = 1;
      #1 clr_exp();
      compare_all();
      @(posedge clk);
      #1 rst = 0;
      bus.req_cpu = 1;
      clr_exp(); tick();

      model_reset();
      access(0, 9, 2, 4'hF, 0, lat);
      chk("restart_latency", 32'(lat), 32'd6);

      // Back-to-back misses: one free way, then four full-set victims from the round-robin.
      for (int t = 10; t <= 14; t++)
         access(1'(t & 1), t, t % WORDS, BYTES'($urandom), 0, lat);

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 3) == 0)
            idle();
         access(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, WORDS - 1)), BYTES'($urandom), 2, lat);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
